// File: rtl/bitstream_unpacker.sv
// Fetches 16-bit bitstream words from SRAM and presents the next 16 unconsumed
// bits, MSB-aligned, to a variable-length decoder that consumes 0..16 bits/cycle.
module bitstream_unpacker #(
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int ADDR_W       = 18
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_address_i,
  input  logic              stop_i,
  output logic [ADDR_W-1:0] SRAM_address_o,
  output logic              SRAM_we_n_o,
  input  logic [15:0]       SRAM_read_data_i,
  output logic [15:0]       bits_o,
  output logic              bits_valid_o,
  input  logic              shift_en_i,
  input  logic [4:0]        shift_amt_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [READ_LATENCY-1:0] rd_vld_q, rd_vld_d;
  logic [CNT_W-1:0]        inflight_q, inflight_d;
  logic [CNT_W-1:0]        fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [15:0]             fifo_mem_q [FIFO_DEPTH];
  logic [15:0]             fifo_mem_d [FIFO_DEPTH];
  logic [31:0]             bitbuf_q, bitbuf_d;
  logic [5:0]              bit_cnt_q, bit_cnt_d;
  logic                    err_q, err_d;

  logic        start_go, issue, ret, capture, shift_ok, shift_bad;
  logic        pop, bypass, push, drain_done;
  logic [31:0] buf_sh;
  logic [5:0]  n_left;
  logic [15:0] word;

  assign ret        = rd_vld_q[READ_LATENCY-1];
  // The drain ends in the cycle the last outstanding read comes back.
  assign drain_done = (state_q == DRAIN) && (inflight_q == CNT_W'(ret));

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i)    state_d = RUN;
      RUN:     if (stop_i)     state_d = DRAIN;
      DRAIN:   if (drain_done) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q != IDLE);
    done_o = drain_done;
  end

  always_comb begin
    start_go  = (state_q == IDLE) && start_i;
    issue     = (state_q == RUN) &&
                (({1'b0, fifo_cnt_q} + {1'b0, inflight_q}) < DEPTH_L);
    capture   = ret && (state_q == RUN);
    shift_ok  = shift_en_i && bits_valid_o && (shift_amt_i <= 5'd16);
    shift_bad = shift_en_i && !shift_ok;

    buf_sh = bitbuf_q;
    n_left = bit_cnt_q;
    if (shift_ok) begin
      buf_sh = bitbuf_q << shift_amt_i;
      n_left = bit_cnt_q - {1'b0, shift_amt_i};
    end

    // Returning data goes straight into an empty-FIFO refill slot, which is
    // what lets the first word reach bits_o READ_LATENCY+2 cycles after start.
    pop    = (n_left <= 6'd16) && (fifo_cnt_q != '0);
    bypass = (n_left <= 6'd16) && (fifo_cnt_q == '0) && capture;
    push   = capture && !bypass;
    word   = pop ? fifo_mem_q[rd_ptr_q] : SRAM_read_data_i;

    bitbuf_d  = buf_sh;
    bit_cnt_d = n_left;
    if (pop || bypass) begin
      bitbuf_d  = buf_sh | ({word, 16'h0000} >> n_left);
      bit_cnt_d = n_left + 6'd16;
    end

    fifo_mem_d = fifo_mem_q;
    if (push) fifo_mem_d[wr_ptr_q] = SRAM_read_data_i;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(ret);
    rd_vld_d   = (rd_vld_q << 1) | READ_LATENCY'(issue);
    addr_d     = issue ? addr_q + 1'b1 : addr_q;
    err_d      = err_q | shift_bad;

    if (start_go) begin
      addr_d     = base_address_i;
      bitbuf_d   = '0;
      bit_cnt_d  = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fifo_cnt_d = '0;
      inflight_d = '0;
      rd_vld_d   = '0;
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      addr_q     <= '0;
      rd_vld_q   <= '0;
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      bitbuf_q   <= '0;
      bit_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      rd_vld_q   <= rd_vld_d;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      bitbuf_q   <= bitbuf_d;
      bit_cnt_q  <= bit_cnt_d;
      err_q      <= err_d;
    end
  end

  // FIFO storage is qualified by the pointers/count, so it needs no reset.
  always_ff @(posedge Clock) begin
    fifo_mem_q <= fifo_mem_d;
  end

  assign SRAM_address_o = addr_q;
  assign SRAM_we_n_o    = 1'b1;
  assign bits_o         = bitbuf_q[31:16];
  assign bits_valid_o   = (bit_cnt_q >= 6'd16);
  assign err_o          = err_q;

endmodule

// File: tb/tb_bitstream_unpacker.sv
// Randomized scoreboard bench for bitstream_unpacker: the expected 16-bit
// window is taken from the bitstream as a flat bit sequence at the consumed position.
module tb_bitstream_unpacker;

  localparam int RL = 2;
  localparam int FD = 4;
  localparam int AW = 18;

  logic          Clock = 1'b0;
  logic          Resetn;
  logic          start_i, stop_i, shift_en_i;
  logic [AW-1:0] base_address_i;
  logic [4:0]    shift_amt_i;
  logic [AW-1:0] SRAM_address_o;
  logic          SRAM_we_n_o;
  logic [15:0]   SRAM_read_data_i;
  logic [15:0]   bits_o;
  logic          bits_valid_o, busy_o, done_o, err_o;

  bitstream_unpacker #(.READ_LATENCY(RL), .FIFO_DEPTH(FD), .ADDR_W(AW)) dut (
    .Clock(Clock), .Resetn(Resetn), .start_i(start_i), .base_address_i(base_address_i),
    .stop_i(stop_i), .SRAM_address_o(SRAM_address_o), .SRAM_we_n_o(SRAM_we_n_o),
    .SRAM_read_data_i(SRAM_read_data_i), .bits_o(bits_o), .bits_valid_o(bits_valid_o),
    .shift_en_i(shift_en_i), .shift_amt_i(shift_amt_i), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o)
  );

  always #10 Clock = ~Clock;

  // SRAM: data for the address presented in a cycle appears RL cycles later.
  logic [15:0]   mem [0:(1<<AW)-1];
  logic [AW-1:0] a_d1, a_d2;
  always @(posedge Clock) begin
    a_d1 <= SRAM_address_o;
    a_d2 <= a_d1;
  end
  assign SRAM_read_data_i = mem[a_d2];

  int            checks = 0;
  int            errors = 0;
  logic [15:0]   exp_q[$];
  logic [AW-1:0] base_m;
  int unsigned   pos_m;
  bit            err_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [15:0] window(input logic [AW-1:0] b, input int unsigned p);
    logic [AW-1:0] a, a1;
    logic [31:0]   two;
    a   = b + AW'(p / 16);
    a1  = a + 1'b1;
    two = {mem[a], mem[a1]} << (p % 16);
    return two[31:16];
  endfunction

  // Monitor: every presented window is compared against the oldest expectation.
  initial begin
    int          pend;
    logic [15:0] e;
    pend = 0;
    forever begin
      @(negedge Clock);
      if (!Resetn) pend = 0;
      else if (exp_q.size() > 0) begin
        if (bits_valid_o) begin
          e = exp_q.pop_front();
          chk("bits_o", 32'(bits_o), 32'(e));
          pend = 0;
        end else begin
          pend++;
          if (pend > 64) begin
            checks++;
            errors++;
            $display("FAIL bits_wait actual=no_valid_window required=valid_within_64_cycles");
            void'(exp_q.pop_front());
            pend = 0;
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge Clock);
    #1;
    chk("err_o", 32'(err_o), 32'(err_m));
  endtask

  task automatic drive(input bit sen, input int amt, input bit sp);
    shift_en_i  = sen;
    shift_amt_i = 5'(amt);
    stop_i      = sp;
    if (sen) begin
      if (bits_valid_o && amt <= 16) begin
        pos_m += amt;
        exp_q.push_back(window(base_m, pos_m));
      end else begin
        err_m = 1'b1;
        if (bits_valid_o) exp_q.push_back(window(base_m, pos_m));
      end
    end
    step();
    shift_en_i = 1'b0;
    stop_i     = 1'b0;
  endtask

  task automatic start_run(input logic [AW-1:0] b, input bit poke);
    int            k;
    logic [AW-1:0] nb;
    nb = b + 1'b1;
    base_address_i = b;
    start_i = 1'b1;
    base_m  = b;
    pos_m   = 0;
    err_m   = 1'b0;
    exp_q.push_back(window(b, 0));
    step();
    start_i = 1'b0;
    chk("first_addr", 32'(SRAM_address_o), 32'(b));
    chk("busy_run", 32'(busy_o), 32'd1);
    if (poke) drive(1'b1, 8, 1'b0);
    else step();
    k = 2;
    chk("next_addr", 32'(SRAM_address_o), 32'(nb));
    while (!bits_valid_o && k < 20) begin
      step();
      k++;
    end
    chk("valid_latency", 32'(k), 32'(RL + 2));
  endtask

  task automatic rand_phase(input int n);
    int amt;
    for (int i = 0; i < n; i++) begin
      amt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(17, 31))
                                        : int'($urandom_range(0, 16));
      drive(1'($urandom_range(0, 1)), amt, 1'b0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0);
  endtask

  task automatic full_rate(input int words);
    int done_w, cyc, gaps;
    bit primed;
    done_w = 0; cyc = 0; gaps = 0; primed = 1'b0;
    while (done_w < words && cyc < 5000) begin
      if (bits_valid_o) begin
        primed = 1'b1;
        drive(1'b1, 16, done_w == words - 1);
        done_w++;
      end else begin
        if (primed) gaps++;
        drive(1'b0, 0, 1'b0);
      end
      cyc++;
    end
    chk("full_rate_words", 32'(done_w), 32'(words));
    chk("full_rate_gaps", 32'(gaps), 32'd0);
  endtask

  // Called one cycle after the stop edge; exp_k is the cycle of the done pulse.
  task automatic drain_check(input int exp_k);
    logic [AW-1:0] a0;
    int pulses, dk, changes;
    a0 = SRAM_address_o;
    pulses = 0; dk = -1; changes = 0;
    for (int k = 1; k <= 20; k++) begin
      if (done_o) begin
        pulses++;
        dk = k;
      end
      if (!busy_o) break;
      if (SRAM_address_o != a0) changes++;
      step();
    end
    chk("done_pulses", 32'(pulses), 32'd1);
    chk("done_cycle", 32'(dk), 32'(exp_k));
    chk("drain_addr_changes", 32'(changes), 32'd0);
    chk("busy_after_drain", 32'(busy_o), 32'd0);
    chk("done_after_drain", 32'(done_o), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_addr"},  32'(SRAM_address_o), 32'd0);
    chk({tag, "_we_n"},  32'(SRAM_we_n_o), 32'd1);
    chk({tag, "_bits"},  32'(bits_o), 32'd0);
    chk({tag, "_valid"}, 32'(bits_valid_o), 32'd0);
    chk({tag, "_busy"},  32'(busy_o), 32'd0);
    chk({tag, "_done"},  32'(done_o), 32'd0);
    chk({tag, "_err"},   32'(err_o), 32'd0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'($urandom);
    mem[1000] = 16'hABCD;
    mem[1001] = 16'h1234;
    Resetn = 1'b0; start_i = 1'b0; stop_i = 1'b0; shift_en_i = 1'b0;
    shift_amt_i = '0; base_address_i = '0;
    base_m = '0; pos_m = 0; err_m = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    #1;
    chk_reset_outputs("reset");
    Resetn = 1'b1;
    step();

    // Priming and the documented shift sequence on ABCD,1234
    start_run(18'd1000, 1'b0);
    drive(1'b0, 0, 1'b0);
    drive(1'b1, 4, 1'b0);
    drive(1'b1, 12, 1'b0);
    drive(1'b1, 16, 1'b0);
    drive(1'b1, 17, 1'b0);
    chk("err_sticky", 32'(err_o), 32'd1);
    rand_phase(300);
    idle(12);
    drive(1'b0, 0, 1'b1);
    drain_check(1);

    // Address wrap, then full-rate consumption ending in a stop with reads in flight
    start_run(18'h3FFFF, 1'b0);
    chk("we_n_run", 32'(SRAM_we_n_o), 32'd1);
    full_rate(1000);
    drain_check(RL);

    // Restart after a drain, with an early consume while the buffer is empty
    start_run(18'd5000, 1'b1);
    rand_phase(150);

    // Asynchronous reset in the middle of a run
    Resetn = 1'b0;
    exp_q.delete();
    err_m = 1'b0;
    pos_m = 0;
    #1;
    chk_reset_outputs("async_reset");
    step();
    Resetn = 1'b1;
    step();
    start_run(18'd1000, 1'b0);
    rand_phase(100);
    idle(12);
    drive(1'b0, 0, 1'b1);
    drain_check(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitstream_unpacker.md
Name: bitstream_unpacker

Overview:
- Sits directly upstream of the lossless-decode (LDD) stage that feeds the IDCT.
- Streams 16-bit words of the compressed bitstream out of external SRAM, starting at a programmable base address.
- Keeps an MSB-aligned bit buffer and always presents the next 16 unconsumed bits to the decoder.
- The decoder consumes a variable number of bits (0..16) per cycle.
- Owns the SRAM read port while active and never writes SRAM.

Parameters:
- READ_LATENCY, 2, clock cycles from SRAM_address_o to valid SRAM_read_data_i.
- FIFO_DEPTH, 4, depth of the word FIFO that absorbs read latency; power of two, must be >= READ_LATENCY+1.
- ADDR_W, 18, SRAM word-address width.

Ports:
- Clock  in  1  system clock (50 MHz).
- Resetn  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle pulse; begins fetching at base_address_i.
- base_address_i  in  ADDR_W  first SRAM word of the bitstream; sampled on start_i.
- stop_i  in  1  one-cycle pulse from the decoder at end of image.
- SRAM_address_o  out  ADDR_W  read address.
- SRAM_we_n_o  out  1  constant 1.
- SRAM_read_data_i  in  16  read data returned READ_LATENCY cycles after the address.
- bits_o  out  16  next 16 unconsumed bits; MSB is the oldest bit.
- bits_valid_o  out  1  buffer holds at least 16 bits.
- shift_en_i  in  1  consume shift_amt_i bits this cycle.
- shift_amt_i  in  5  bits to consume, 0..16.
- busy_o  out  1  block is not IDLE.
- done_o  out  1  one-cycle pulse when the drain completes.
- err_o  out  1  sticky; set on an illegal shift, cleared by start_i.

Behaviour:
- Reset values:
  - SRAM_address_o=0, SRAM_we_n_o=1, bits_o=0.
  - bits_valid_o=0, busy_o=0, done_o=0, err_o=0.
  - Buffer, bit count, FIFO, in-flight counter and state all cleared.
  - Reset asserted mid-operation aborts immediately; in-flight read data is never captured.
- States:
  - IDLE: start_i -> RUN; load address counter with base_address_i, clear buffer, FIFO, in-flight count and err_o.
  - RUN: issue reads; stop_i -> DRAIN.
  - DRAIN: issue no new reads; discard returning data; when in-flight count == 0 -> IDLE and pulse done_o for one cycle.
  - start_i outside IDLE is ignored.
- Read issue (RUN only):
  - A read is issued in a cycle iff fifo_count + inflight < FIFO_DEPTH.
  - SRAM_address_o = current counter; counter increments by 1 after each issue and wraps modulo 2^ADDR_W.
  - A READ_LATENCY-deep valid shift register tags returning data; tagged data is pushed into the FIFO.
- Bit buffer:
  - 32 bits, MSB-aligned; count 0..32.
  - bits_o = buf[31:16]; bits_valid_o = (count >= 16).
- Consumption:
  - shift_en_i is honoured only when bits_valid_o=1 and shift_amt_i <= 16.
  - On a legal shift: buf <<= amt, count -= amt.
  - If bits_valid_o=0 or shift_amt_i > 16: no consumption, err_o set.
  - shift_amt_i=0 with shift_en_i is legal and is a no-op.
- Refill, same cycle as a shift:
  - Let n = count after the shift.
  - If n <= 16 and the FIFO is non-empty: pop one word, OR it into buf at bit positions [31-n : 16-n], count = n+16.
  - At most one word is appended per cycle.
- Simultaneous events:
  - FIFO push and pop in the same cycle leave fifo_count unchanged.
  - stop_i together with shift_en_i: the shift is honoured, then the state moves to DRAIN.
- Bits_o latency from start_i:
  - First word valid at cycle READ_LATENCY+2 after start_i.
  - bits_valid_o at cycle READ_LATENCY+2 (first word loaded, count=16).

Test Plan:
- Reset and start: SRAM[1000..]=16'hABCD,16'h1234; start_i with base 1000 -> first read address 1000, addresses increment by 1. bits_valid_o rises READ_LATENCY+2 cycles after start_i with bits_o=ABCD; one cycle later count=32.
- Variable shifts: after the case above, shift 4 -> bits_o=BCD1; shift 12 -> bits_o=1234; shift 16 with an empty FIFO -> bits_valid_o=0 until the next word arrives.
- Illegal shift: shift_amt_i=17, or shift_en_i while bits_valid_o=0 -> buffer unchanged, err_o=1 and held until the next start_i.
- Full-rate consumption: shift 16 every cycle for 1000 words -> bits_o sequence equals SRAM contents with no gaps after priming. FIFO never overflows; fifo_count + inflight <= FIFO_DEPTH every cycle.
- Stop and drain: stop_i with 2 reads in flight -> no new addresses issued; done_o pulses exactly when the last read returns; a following start_i at base 5000 yields bits_o=SRAM[5000] with no stale data.
- Async reset mid-RUN: Resetn low for 1 cycle -> all outputs at reset values in the same cycle; after release, a start_i behaves as from a clean reset. Address wrap check: base 18'h3FFFF -> the next address is 0.
